// File: rtl/multicycle_addsub.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_addsub
// Description : Digit-serial two's-complement adder/subtractor. An accepted
//               start latches A and B (B inverted when subtracting) and the
//               carry-in. The block then adds DIGIT bits per cycle, LSB first,
//               over WIDTH/DIGIT cycles. It then shows the result for one
//               cycle, with a done pulse.
//               Optional feature macro: MULTICYCLE_ADDSUB_OVF_EN enables the
//               signed-overflow flag. Without the macro, ovf is tied to 0.
// Ports       : clk          - clock, rising edge
//               rst          - synchronous active-high reset
//               start        - begin an operation (accepted in IDLE/DONE)
//               addsub       - 0: A+B, 1: A-B (sampled with start)
//               A, B         - WIDTH-bit operands (sampled with start)
//               sum          - registered WIDTH-bit result
//               cout         - carry out of MSB (subtract: 1 = no borrow)
//               ovf          - signed overflow flag
//               done         - one-cycle result-valid pulse
//               calculating  - high while digits are being processed
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_addsub #(
    parameter int WIDTH = 6,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             addsub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             done,
    output logic             calculating
);

    localparam int c_STEPS = WIDTH / DIGIT;
    localparam int c_CNT_W = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(c_STEPS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0] r_step;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_accept;
    logic               w_last;
    logic [DIGIT:0]     w_digit;
    logic [DIGIT-1:0]   w_res;
    logic               w_c;
    logic [WIDTH-1:0]   w_acc_next;

    // A new operation may start only when no digits are in flight.
    assign w_accept = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_last   = (r_state == c_ST_CALC) && (r_step == c_LAST_STEP);

    // The operands shift right each step, so the active digit is always at
    // the bottom of the registers.
    assign w_digit = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                   + (DIGIT + 1)'(r_carry);
    assign w_res   = w_digit[DIGIT-1:0];
    assign w_c     = w_digit[DIGIT];

    // Result digits enter at the top and move down. After the last step, the
    // first digit sits at bit 0.
    assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_res) << (WIDTH - DIGIT));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        calculating  = 1'b0;
        done         = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = c_ST_CALC;
                end
            end
            c_ST_CALC: begin
                calculating = 1'b1;
                if (r_step == c_LAST_STEP) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                done         = 1'b1;
                w_state_next = start ? c_ST_CALC : c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_acc   <= '0;
            r_step  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1.
            r_a     <= A;
            r_b     <= B ^ {WIDTH{addsub}};
            r_carry <= addsub;
            r_step  <= '0;
        end else if (r_state == c_ST_CALC) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_c;
            r_acc   <= w_acc_next;
            r_step  <= r_step + 1'b1;
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_c;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

`ifdef MULTICYCLE_ADDSUB_OVF_EN
    logic r_ovf;
    logic w_ovf;

    // On the last step, the MSB of each operand sits at bit DIGIT-1. The carry
    // into the MSB is recovered as a ^ b ^ s at that bit.
    assign w_ovf = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_res[DIGIT-1] ^ w_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_addsub
// Description : Directed self-checking bench for multicycle_addsub. WIDTH is
//               6. Three instances use DIGIT = 1, 2 and 6 and run side by
//               side on the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_addsub;

`ifdef MULTICYCLE_ADDSUB_OVF_EN
    localparam logic c_OVF_EN = 1'b1;
`else
    localparam logic c_OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       r_start;
    logic       r_addsub;
    logic [5:0] r_a;
    logic [5:0] r_b;

    logic [5:0] w_sum  [3];
    logic       w_cout [3];
    logic       w_ovf  [3];
    logic       w_done [3];
    logic       w_calc [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_addsub #(.WIDTH(6), .DIGIT(1)) u_dut_d1 (
        .clk(clk), .rst(rst), .start(r_start), .addsub(r_addsub), .A(r_a), .B(r_b),
        .sum(w_sum[0]), .cout(w_cout[0]), .ovf(w_ovf[0]), .done(w_done[0]),
        .calculating(w_calc[0])
    );

    multicycle_addsub #(.WIDTH(6), .DIGIT(2)) u_dut_d2 (
        .clk(clk), .rst(rst), .start(r_start), .addsub(r_addsub), .A(r_a), .B(r_b),
        .sum(w_sum[1]), .cout(w_cout[1]), .ovf(w_ovf[1]), .done(w_done[1]),
        .calculating(w_calc[1])
    );

    multicycle_addsub #(.WIDTH(6), .DIGIT(6)) u_dut_d6 (
        .clk(clk), .rst(rst), .start(r_start), .addsub(r_addsub), .A(r_a), .B(r_b),
        .sum(w_sum[2]), .cout(w_cout[2]), .ovf(w_ovf[2]), .done(w_done[2]),
        .calculating(w_calc[2])
    );

    function automatic int steps_of(input int i);
        return (i == 0) ? 6 : ((i == 1) ? 3 : 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s s%0d sum", tag, steps_of(i)), 32'(w_sum[i]), 32'd0);
            check($sformatf("%s s%0d cout", tag, steps_of(i)), 32'(w_cout[i]), 32'd0);
            check($sformatf("%s s%0d ovf", tag, steps_of(i)), 32'(w_ovf[i]), 32'd0);
            check($sformatf("%s s%0d done", tag, steps_of(i)), 32'(w_done[i]), 32'd0);
            check($sformatf("%s s%0d calc", tag, steps_of(i)), 32'(w_calc[i]), 32'd0);
        end
    endtask

    // One operation on all three instances. With disturb set, the inputs are
    // changed and start is pulsed in cycle 2. The DIGIT=6 instance is in DONE
    // at that point and legitimately accepts the pulse, so it is not checked.
    task automatic run_op(input string tag, input logic [5:0] a, input logic [5:0] b,
                          input logic as, input logic [5:0] es, input logic ec,
                          input logic eo, input bit disturb);
        int first_done [3];
        int n_done     [3];
        int n_calc     [3];
        for (int i = 0; i < 3; i++) begin
            first_done[i] = 0;
            n_done[i]     = 0;
            n_calc[i]     = 0;
        end
        @(negedge clk);
        r_a      = a;
        r_b      = b;
        r_addsub = as;
        r_start  = 1'b1;
        @(posedge clk);
        #1;
        r_start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (w_calc[i]) n_calc[i]++;
                if (w_done[i]) begin
                    n_done[i]++;
                    if (first_done[i] == 0) first_done[i] = c;
                end
            end
            if (disturb && c == 2) begin
                r_a      = ~a;
                r_b      = 6'b101010;
                r_addsub = ~as;
                r_start  = 1'b1;
            end else if (disturb && c == 3) begin
                r_start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            if (!(disturb && i == 2)) begin
                check($sformatf("%s s%0d sum", tag, steps_of(i)), 32'(w_sum[i]), 32'(es));
                check($sformatf("%s s%0d cout", tag, steps_of(i)), 32'(w_cout[i]), 32'(ec));
                check($sformatf("%s s%0d ovf", tag, steps_of(i)), 32'(w_ovf[i]), 32'(eo & c_OVF_EN));
                check($sformatf("%s s%0d done_cycle", tag, steps_of(i)), 32'(first_done[i]),
                      32'(steps_of(i) + 1));
                check($sformatf("%s s%0d done_pulses", tag, steps_of(i)), 32'(n_done[i]), 32'd1);
                check($sformatf("%s s%0d calc_cycles", tag, steps_of(i)), 32'(n_calc[i]),
                      32'(steps_of(i)));
            end
        end
    endtask

    initial begin
        int n_late_done;
        int first_done  [3];
        int second_done [3];

        rst      = 1'b1;
        r_start  = 1'b0;
        r_addsub = 1'b0;
        r_a      = '0;
        r_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        run_op("add_1_1",     6'b000001, 6'b000001, 1'b0, 6'b000010, 1'b0, 1'b0, 1'b0);
        run_op("sub_22_9",    6'b010110, 6'b001001, 1'b1, 6'b001101, 1'b1, 1'b0, 1'b0);
        run_op("add_63_1",    6'b111111, 6'b000001, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
        run_op("add_neg_ovf", 6'b101101, 6'b100110, 1'b0, 6'b010011, 1'b1, 1'b1, 1'b0);
        run_op("sub_neg",     6'b110001, 6'b001001, 1'b1, 6'b101000, 1'b1, 1'b0, 1'b0);
        run_op("add_35_26",   6'b100011, 6'b011010, 1'b0, 6'b111101, 1'b0, 1'b0, 1'b0);
        run_op("ignore_calc", 6'b000001, 6'b000001, 1'b0, 6'b000010, 1'b0, 1'b0, 1'b1);
        run_op("sub_22_9b",   6'b010110, 6'b001001, 1'b1, 6'b001101, 1'b1, 1'b0, 1'b0);

        // Reset in CALC cycle 3 aborts the operation and clears the outputs.
        @(negedge clk);
        r_a      = 6'b000001;
        r_b      = 6'b000001;
        r_addsub = 1'b0;
        r_start  = 1'b1;
        @(posedge clk);
        #1;
        r_start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("midrst pre calc", 32'(w_calc[0]), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_zero("midrst");
        n_late_done = 0;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (w_done[i]) n_late_done++;
            end
            @(posedge clk);
            #1;
        end
        check("midrst no_done", 32'(n_late_done), 32'd0);

        // Start held high: each DONE is followed directly by a new CALC.
        for (int i = 0; i < 3; i++) begin
            first_done[i]  = 0;
            second_done[i] = 0;
        end
        @(negedge clk);
        r_a      = 6'b100011;
        r_b      = 6'b011010;
        r_addsub = 1'b0;
        r_start  = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 16; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (w_done[i]) begin
                    if (first_done[i] == 0) first_done[i] = c;
                    else if (second_done[i] == 0) second_done[i] = c;
                end
            end
            @(posedge clk);
            #1;
        end
        r_start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b s%0d first_done", steps_of(i)), 32'(first_done[i]),
                  32'(steps_of(i) + 1));
            check($sformatf("b2b s%0d second_done", steps_of(i)), 32'(second_done[i]),
                  32'(2 * (steps_of(i) + 1)));
            check($sformatf("b2b s%0d sum", steps_of(i)), 32'(w_sum[i]), 32'(6'b111101));
            check($sformatf("b2b s%0d cout", steps_of(i)), 32'(w_cout[i]), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
